// File: rtl/proc16_pkg.sv
// Shared register-file constants: default widths and the depth helper.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package proc16_pkg;

    localparam int PKG_DATA_W = 16;
    localparam int PKG_ADDR_W = 3;

    // Number of registers addressed by an aw-bit address.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int PKG_DEPTH = depth_of(PKG_ADDR_W);

endpackage

// File: rtl/regfile_rdport.sv
// One read port: address mux over the register array, optional write forwarding, output registers.
// Latency: 1 cycle from rd to rd_data/rd_pend; outputs hold when rd=0.
// Backpressure: none; a read is accepted every cycle.
//
// Ports: rd/rd_addr request; regs/pend are the current array state; byp_vld/byp_data/byp_pend
// override the array when the top decides a same-cycle write must be forwarded.
module regfile_rdport
    import proc16_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int ADDR_W = PKG_ADDR_W
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  rd,
    input  logic [ADDR_W-1:0]                     rd_addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]    regs,
    input  logic [(1<<ADDR_W)-1:0]                pend,
    input  logic                                  byp_vld,
    input  logic [DATA_W-1:0]                     byp_data,
    input  logic                                  byp_pend,
    output logic [DATA_W-1:0]                     rd_data,
    output logic                                  rd_pend
);

    logic [DATA_W-1:0] data_sel;
    logic              pend_sel;

    always_comb begin
        data_sel = regs[rd_addr];
        pend_sel = pend[rd_addr];
        if (byp_vld) begin
            data_sel = byp_data;
            pend_sel = byp_pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_pend <= 1'b0;
        end else if (rd) begin
            rd_data <= data_sel;
            rd_pend <= pend_sel;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with a per-register scoreboard pending bit.
// Latency: writes/reserves visible next cycle; reads return registered data 1 cycle after request.
// Backpressure: none; pend is advisory and never blocks a read or write.
//
// Ports: wr/wr_addr/wr_data write; rd_x/rd_addr_x read requests -> rd_data_x/rd_pend_x;
// rsv/rsv_addr scoreboard reserve; pend_vec live scoreboard bits.
// Optional macro REGFILE_BYPASS_EN: a same-cycle read of wr_addr returns wr_data and the
// post-update pend bit; without it the pre-write contents and pend bit are returned.
module regfile_2r1w
    import proc16_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int ADDR_W = PKG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      rd_a,
    input  logic [ADDR_W-1:0]         rd_addr_a,
    input  logic                      rd_b,
    input  logic [ADDR_W-1:0]         rd_addr_b,
    output logic [DATA_W-1:0]         rd_data_a,
    output logic [DATA_W-1:0]         rd_data_b,
    output logic                      rd_pend_a,
    output logic                      rd_pend_b,
    input  logic                      rsv,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic [(1<<ADDR_W)-1:0]    pend_vec
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]             pend_q;
    logic [DEPTH-1:0]             pend_d;

    // Reserve is applied after the write-clear so a same-address reserve wins.
    always_comb begin
        pend_d = pend_q;
        if (wr) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv) begin
            pend_d[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            if (wr) begin
                regs_q[wr_addr] <= wr_data;
            end
            pend_q <= pend_d;
        end
    end

    assign pend_vec = pend_q;

    logic byp_a;
    logic byp_b;
    logic byp_pend;

`ifdef REGFILE_BYPASS_EN
    assign byp_a    = wr && (wr_addr == rd_addr_a);
    assign byp_b    = wr && (wr_addr == rd_addr_b);
    assign byp_pend = pend_d[wr_addr];
`else
    assign byp_a    = 1'b0;
    assign byp_b    = 1'b0;
    assign byp_pend = 1'b0;
`endif

    regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd_a),
        .rd_addr  (rd_addr_a),
        .regs     (regs_q),
        .pend     (pend_q),
        .byp_vld  (byp_a),
        .byp_data (wr_data),
        .byp_pend (byp_pend),
        .rd_data  (rd_data_a),
        .rd_pend  (rd_pend_a)
    );

    regfile_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rdport_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd_b),
        .rd_addr  (rd_addr_b),
        .regs     (regs_q),
        .pend     (pend_q),
        .byp_vld  (byp_b),
        .byp_data (wr_data),
        .byp_pend (byp_pend),
        .rd_data  (rd_data_b),
        .rd_pend  (rd_pend_b)
    );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an array-based model of the register file and scoreboard.
// Follows REGFILE_BYPASS_EN the same way the design build does.
module tb_regfile_2r1w;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_a = 1'b0;
    logic [2:0]  rd_addr_a = '0;
    logic        rd_b = 1'b0;
    logic [2:0]  rd_addr_b = '0;
    logic        rsv = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        rd_pend_a;
    logic        rd_pend_b;
    logic [7:0]  pend_vec;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr        (wr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_a      (rd_a),
        .rd_addr_a (rd_addr_a),
        .rd_b      (rd_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .rd_pend_a (rd_pend_a),
        .rd_pend_b (rd_pend_b),
        .rsv       (rsv),
        .rsv_addr  (rsv_addr),
        .pend_vec  (pend_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [8];
    bit          m_pend [8];
    logic [15:0] m_a, m_b;
    bit          m_pa, m_pb;

    // What a read of address a returns this cycle, given the pending write/reserve.
    task automatic model_read(input logic [2:0] a, output logic [15:0] d, output bit p);
        if (BYP && wr && wr_addr == a) begin
            d = wr_data;
            p = rsv && (rsv_addr == a);
        end else begin
            d = m_mem[a];
            p = m_pend[a];
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_a = '0; m_b = '0; m_pa = 1'b0; m_pb = 1'b0;
        end else begin
            if (rd_a) model_read(rd_addr_a, m_a, m_pa);
            if (rd_b) model_read(rd_addr_b, m_b, m_pb);
            if (wr) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv) m_pend[rsv_addr] = 1'b1;
        end
    end

    function automatic logic [7:0] model_pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_rd_data_a", 32'(rd_data_a), 32'(m_a));
            chk("cyc_rd_data_b", 32'(rd_data_b), 32'(m_b));
            chk("cyc_rd_pend_a", 32'(rd_pend_a), 32'(m_pa));
            chk("cyc_rd_pend_b", 32'(rd_pend_b), 32'(m_pb));
            chk("cyc_pend_vec",  32'(pend_vec),  32'(model_pend_vec()));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit w, input logic [2:0] wa, input logic [15:0] wd,
                       input bit ra, input logic [2:0] aa, input bit rb, input logic [2:0] ab,
                       input bit rs, input logic [2:0] rsa);
        wr = w; wr_addr = wa; wr_data = wd;
        rd_a = ra; rd_addr_a = aa; rd_b = rb; rd_addr_b = ab;
        rsv = rs; rsv_addr = rsa;
        step();
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_data_a", 32'(rd_data_a), 0);
        chk("reset_rd_data_b", 32'(rd_data_b), 0);
        chk("reset_pend_vec",  32'(pend_vec),  0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Read both ports at 0 and 7 straight after reset.
        drv(0, 0, 0, 1, 0, 1, 7, 0, 0);
        chk("post_reset_rd_a", 32'(rd_data_a), 0);
        chk("post_reset_rd_b", 32'(rd_data_b), 0);
        chk("post_reset_pend_a", 32'(rd_pend_a), 0);
        chk("post_reset_pend_b", 32'(rd_pend_b), 0);

        // Basic writes then a dual read.
        drv(1, 0, 16'h0001, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 16'h0002, 0, 0, 0, 0, 0, 0);
        drv(1, 2, 16'h0001, 0, 0, 0, 0, 0, 0);
        drv(1, 3, 16'h0003, 0, 0, 0, 0, 0, 0);
        drv(1, 7, 16'h0005, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 3, 1, 7, 0, 0);
        chk("rd_a_addr3", 32'(rd_data_a), 32'h0003);
        chk("rd_b_addr7", 32'(rd_data_b), 32'h0005);

        // Both ports on the same address.
        drv(0, 0, 0, 1, 1, 1, 1, 0, 0);
        chk("same_addr_a", 32'(rd_data_a), 32'h0002);
        chk("same_addr_b", 32'(rd_data_b), 32'h0002);

        // Read-during-write on address 2 (holds 0x0001).
        drv(1, 2, 16'hBEEF, 1, 2, 0, 0, 0, 0);
        chk("rdw_addr2", 32'(rd_data_a), BYP ? 32'hBEEF : 32'h0001);
        drv(0, 0, 0, 1, 2, 0, 0, 0, 0);
        chk("after_write_addr2", 32'(rd_data_a), 32'hBEEF);

        // Scoreboard reserve / clear / reserve-wins.
        drv(0, 0, 0, 0, 0, 0, 0, 1, 5);
        chk("rsv5_pend_vec", 32'(pend_vec), 32'h20);
        drv(1, 5, 16'h0055, 0, 0, 0, 0, 0, 0);
        chk("wr5_pend_vec", 32'(pend_vec), 32'h00);
        drv(1, 5, 16'h0066, 1, 5, 0, 0, 1, 5);
        chk("rsv_wr5_pend_vec", 32'(pend_vec), 32'h20);
        chk("rsv_wr5_rd_pend", 32'(rd_pend_a), BYP ? 1 : 0);
        drv(0, 0, 0, 1, 5, 0, 0, 0, 0);
        chk("rd5_pend_set", 32'(rd_pend_a), 1);
        chk("rd5_data", 32'(rd_data_a), 32'h0066);

        // Hold on rd_a=0 while the register is rewritten.
        drv(0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("hold_first_read", 32'(rd_data_a), 32'h0002);
        drv(1, 1, 16'h1234, 0, 1, 0, 0, 0, 0);
        chk("hold_during_write", 32'(rd_data_a), 32'h0002);
        idle();
        chk("hold_idle", 32'(rd_data_a), 32'h0002);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 2000; n++) begin
            drv(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom),
                1'($urandom_range(0, 3) == 0), 3'($urandom));
        end

        // Mid-clock reset after live state.
        drv(1, 4, 16'hAAAA, 0, 0, 0, 0, 1, 6);
        drv(0, 0, 0, 1, 4, 1, 4, 1, 2);
        chk("pre_reset_data", 32'(rd_data_a), 32'hAAAA);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_data_a", 32'(rd_data_a), 0);
        chk("midrst_rd_data_b", 32'(rd_data_b), 0);
        chk("midrst_rd_pend_a", 32'(rd_pend_a), 0);
        chk("midrst_rd_pend_b", 32'(rd_pend_b), 0);
        chk("midrst_pend_vec",  32'(pend_vec),  0);
        // Requests during reset must be ignored.
        drv(1, 3, 16'h5555, 1, 3, 1, 3, 1, 3);
        drv(1, 4, 16'h6666, 1, 4, 1, 4, 1, 4);
        rst_n = 1'b1;
        idle();
        chk("after_rst_pend_vec", 32'(pend_vec), 0);
        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 0, 1, 3'(i), 1, 3'(7 - i), 0, 0);
            chk("after_rst_rd_a", 32'(rd_data_a), 0);
            chk("after_rst_rd_b", 32'(rd_data_b), 0);
        end

        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 16, for the register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3, for the address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports wr, input, 1; wr_addr, input, ADDR_W; wr_data, input, DATA_W; together the write port.
REQ-006 SHALL have ports rd_a and rd_b, input, 1 each; rd_addr_a and rd_addr_b, input, ADDR_W each; together the read-port requests.
REQ-007 SHALL have ports rd_data_a and rd_data_b, output, DATA_W each, for the registered read data.
REQ-008 SHALL have ports rd_pend_a and rd_pend_b, output, 1 each, for the registered scoreboard-pending flag of the register read.
REQ-009 SHALL have ports rsv, input, 1, and rsv_addr, input, ADDR_W, for the scoreboard reserve request.
REQ-010 SHALL have port pend_vec, output, DEPTH, for the live scoreboard bits (bit i = register i pending).

Function
REQ-011 SHALL write wr_data into register wr_addr at the clock edge when wr=1.
REQ-012 SHALL return the read result one cycle after the request: when rd_a=1, rd_data_a <= reg[rd_addr_a] and rd_pend_a <= pend[rd_addr_a]; port B is identical and independent.
REQ-013 SHALL hold rd_data_x and rd_pend_x at their previous values when rd_x=0.
REQ-014 SHALL permit both ports to read the same address in one cycle; both SHALL return identical data.
REQ-015 SHALL set pend[rsv_addr] at the edge when rsv=1.
REQ-016 SHALL clear pend[wr_addr] at the edge when wr=1, unless REQ-017 applies.
REQ-017 SHALL leave pend set when rsv=1 and wr=1 target the same address in the same cycle; the reserve wins.
REQ-018 SHALL write regardless of the pend state; pend is advisory only and never blocks a write or a read.
REQ-019 SHALL decode every address in 0..DEPTH-1 with no reserved or hard-wired register, and SHALL have no out-of-range case.
REQ-020 SHALL evaluate read-during-write to the same address per the Configuration section; pend reads follow the same rule, using the post-update pend value under bypass.

Reset
REQ-021 SHALL, while rst_n=0, immediately clear all registers, pend_vec, rd_data_a/b and rd_pend_a/b to 0, independent of clk.
REQ-022 SHALL ignore wr, rsv and rd requests sampled while rst_n=0; the first operation SHALL take effect on the first rising edge after rst_n rises.

Configuration
REQ-023 SHALL, with macro REGFILE_BYPASS_EN defined, forward the write: a same-cycle read of wr_addr returns wr_data, and rd_pend reflects REQ-016/017.
REQ-024 SHALL, without REGFILE_BYPASS_EN, return the pre-write register contents and pre-update pend bit for a same-cycle read of wr_addr.

Structure
REQ-025 SHALL place the DATA_W/ADDR_W defaults and a DEPTH helper constant in shared package proc16_pkg.
REQ-026 SHALL be implemented as one top-level module plus one sub-module, regfile_rdport, instantiated twice (mux plus bypass plus output registers).

Verification
REQ-027 SHALL cover this scenario: after reset, read both ports at addresses 0 and 7, giving rd_data=0 and rd_pend=0 on both ports one cycle later.
REQ-028 SHALL cover this scenario: write 0x0001,0x0002,0x0001,0x0003 to addresses 0..3 and 0x0005 to address 7, then read A=3 and B=7, giving 0x0003 and 0x0005 on the next cycle.
REQ-029 SHALL cover this scenario: with reg2=0x0001, write 0xBEEF to address 2 while reading A=2, giving 0xBEEF with the macro defined and 0x0001 without it.
REQ-030 SHALL cover this scenario: rsv on address 5, giving pend_vec=0x20; then a write to address 5, giving pend_vec=0x00; then rsv and wr on address 5 together, giving pend_vec=0x20.
REQ-031 SHALL cover this scenario: rd_a=1 at address 1 for one cycle, then rd_a=0 while address 1 is rewritten, giving rd_data_a holding its old value.
REQ-032 SHALL cover this scenario: assert rst_n=0 mid-clock after writes, giving all outputs 0 before the next edge and all registers reading 0 afterwards.
